// File: rtl/axi4l_reg_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axi4l_pkg
//  Purpose  : Shared types for the AXI4-Lite to register-bus bridge.
//             - axi4l_resp_t         : AXI response encoding
//             - axi4l_bridge_state_t : bridge FSM state encoding
//             - axi4l_lane_bits()    : number of byte-lane address bits
//  Revision : 1.0  initial release
// ============================================================================
package axi4l_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi4l_resp_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4
    } axi4l_bridge_state_t;

    // Byte-lane bits dropped when turning an AXI byte address into a word address.
    function automatic int axi4l_lane_bits(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi4l_reg_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module   : axi4l_if
//  Purpose  : AXI4-Lite bus bundle (AW, W, B, AR, R channels).
//  Ports    : master modport drives addresses/data/valids and B/R readies;
//             slave modport drives A/W readies and the B/R responses.
//  Revision : 1.0  initial release
// ============================================================================
interface axi4l_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface
`default_nettype wire

// File: rtl/axi4l_chan_hold.sv
`default_nettype none
// ============================================================================
//  Module   : axi4l_chan_hold
//  Purpose  : One-entry valid/ready holding register for an AXI channel.
//             Accepts a beat whenever empty; stays full until i_clear.
//  Ports    : axi4l_aclk/axi4l_arstn - clock, synchronous active-low reset
//             i_valid/o_ready/i_data - upstream channel
//             i_clear                - empty the entry (response done)
//             o_full/o_data          - held beat
//  Revision : 1.0  initial release
// ============================================================================
module axi4l_chan_hold #(
    parameter int WIDTH = 32
) (
    input  wire              axi4l_aclk,
    input  wire              axi4l_arstn,
    input  wire              i_valid,
    output logic             o_ready,
    input  wire [WIDTH-1:0]  i_data,
    input  wire              i_clear,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data
);
    logic             r_full;
    logic             r_en;
    logic [WIDTH-1:0] r_data;

    // r_en keeps ready low while reset is asserted, so the channel does not
    // advertise space until the first edge after reset is released.
    always_ff @(posedge axi4l_aclk) begin
        if (!axi4l_arstn) begin
            r_full <= 1'b0;
            r_en   <= 1'b0;
            r_data <= '0;
        end else begin
            r_en <= 1'b1;
            if (i_clear) begin
                r_full <= 1'b0;
            end else if (i_valid && o_ready) begin
                r_full <= 1'b1;
                r_data <= i_data;
            end
        end
    end

    assign o_ready = r_en & ~r_full;
    assign o_full  = r_full;
    assign o_data  = r_data;
endmodule
`default_nettype wire

// File: rtl/axi4l_reg_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : axi4l_reg_bridge
//  Purpose  : AXI4-Lite slave that serialises reads and writes onto a simple
//             level-request / ack register bus, one access in flight.
//  Ports    : axi4l_aclk, axi4l_arstn (sync, active-low)
//             s            - axi4l_if slave modport (AW/W/B/AR/R)
//             reg_addr     - word address (byte-lane bits dropped)
//             reg_wr_en    - write request (level)
//             reg_rd_en    - read request (level)
//             reg_wdata    - write data
//             reg_wstrb    - byte strobes
//             reg_rdata    - read data, sampled with reg_ack
//             reg_ack      - request done
//             reg_err      - qualifies reg_ack, returns SLVERR
//  Config   : AXI4L_REG_TIMEOUT_EN - when defined, a request without reg_ack
//             for TIMEOUT_CYCLES cycles is dropped and answered with SLVERR.
//  Revision : 1.0  initial release
// ============================================================================
module axi4l_reg_bridge
    import axi4l_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,   // 32 or 64
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire                                        axi4l_aclk,
    input  wire                                        axi4l_arstn,
    axi4l_if.slave                                     s,
    output logic [ADDR_WIDTH-$clog2(DATA_WIDTH/8)-1:0] reg_addr,
    output logic                                       reg_wr_en,
    output logic                                       reg_rd_en,
    output logic [DATA_WIDTH-1:0]                      reg_wdata,
    output logic [DATA_WIDTH/8-1:0]                    reg_wstrb,
    input  wire  [DATA_WIDTH-1:0]                      reg_rdata,
    input  wire                                        reg_ack,
    input  wire                                        reg_err
);
    localparam int c_lsb = axi4l_lane_bits(DATA_WIDTH);
    localparam int c_aw  = ADDR_WIDTH - c_lsb;
    localparam int c_sw  = DATA_WIDTH / 8;

    axi4l_bridge_state_t r_state;
    axi4l_bridge_state_t w_state_nxt;

    logic                     w_aw_full;
    logic                     w_w_full;
    logic                     w_ar_full;
    logic [c_aw-1:0]          w_aw_addr;
    logic [c_aw-1:0]          w_ar_addr;
    logic [DATA_WIDTH+c_sw-1:0] w_w_beat;
    logic                     w_wr_elig;
    logic                     w_rd_elig;
    logic                     w_wr_done;
    logic                     w_rd_done;
    logic                     w_timeout;

    axi4l_resp_t              r_bresp;
    axi4l_resp_t              r_rresp;
    logic [DATA_WIDTH-1:0]    r_rdata;
    logic                     r_prio_wr;

    // Byte-lane address bits never reach the register bus.
    logic w_unused;
    assign w_unused = &{1'b0, s.awaddr[c_lsb-1:0], s.araddr[c_lsb-1:0]};

    // ------------------------------------------------------------------
    // Channel holding registers. Each empties only on its B/R handshake,
    // which bounds the bridge to one outstanding write and one read.
    // ------------------------------------------------------------------
    axi4l_chan_hold #(.WIDTH(c_aw)) u_aw_hold (
        .axi4l_aclk  (axi4l_aclk),
        .axi4l_arstn (axi4l_arstn),
        .i_valid     (s.awvalid),
        .o_ready     (s.awready),
        .i_data      (s.awaddr[ADDR_WIDTH-1:c_lsb]),
        .i_clear     (w_wr_done),
        .o_full      (w_aw_full),
        .o_data      (w_aw_addr)
    );

    axi4l_chan_hold #(.WIDTH(DATA_WIDTH+c_sw)) u_w_hold (
        .axi4l_aclk  (axi4l_aclk),
        .axi4l_arstn (axi4l_arstn),
        .i_valid     (s.wvalid),
        .o_ready     (s.wready),
        .i_data      ({s.wdata, s.wstrb}),
        .i_clear     (w_wr_done),
        .o_full      (w_w_full),
        .o_data      (w_w_beat)
    );

    axi4l_chan_hold #(.WIDTH(c_aw)) u_ar_hold (
        .axi4l_aclk  (axi4l_aclk),
        .axi4l_arstn (axi4l_arstn),
        .i_valid     (s.arvalid),
        .o_ready     (s.arready),
        .i_data      (s.araddr[ADDR_WIDTH-1:c_lsb]),
        .i_clear     (w_rd_done),
        .o_full      (w_ar_full),
        .o_data      (w_ar_addr)
    );

    assign w_wr_elig = w_aw_full & w_w_full;
    assign w_rd_elig = w_ar_full;

    // ------------------------------------------------------------------
    // Request timeout
    // ------------------------------------------------------------------
`ifdef AXI4L_REG_TIMEOUT_EN
    localparam int c_cw = $clog2(TIMEOUT_CYCLES + 1);
    logic            w_in_req;
    logic [c_cw-1:0] r_tmo_cnt;

    assign w_in_req = (r_state == ST_WR_REQ) || (r_state == ST_RD_REQ);

    // Counts request cycles already completed; the last allowed cycle is
    // the one where the count equals TIMEOUT_CYCLES-1.
    always_ff @(posedge axi4l_aclk) begin
        if (!axi4l_arstn || !w_in_req) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign w_timeout = w_in_req && !reg_ack &&
                       (r_tmo_cnt == c_cw'(TIMEOUT_CYCLES - 1));
`else
    localparam int c_unused_timeout = TIMEOUT_CYCLES;
    assign w_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge axi4l_aclk) begin
        if (!axi4l_arstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_wr_elig && (!w_rd_elig || r_prio_wr)) begin
                    w_state_nxt = ST_WR_REQ;
                end else if (w_rd_elig) begin
                    w_state_nxt = ST_RD_REQ;
                end
            end
            ST_WR_REQ: begin
                if (reg_ack || w_timeout) begin
                    w_state_nxt = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (s.bready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RD_REQ: begin
                if (reg_ack || w_timeout) begin
                    w_state_nxt = ST_RD_RESP;
                end
            end
            ST_RD_RESP: begin
                if (s.rready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        reg_wr_en = 1'b0;
        reg_rd_en = 1'b0;
        s.bvalid  = 1'b0;
        s.rvalid  = 1'b0;
        w_wr_done = 1'b0;
        w_rd_done = 1'b0;
        case (r_state)
            ST_WR_REQ:  reg_wr_en = 1'b1;
            ST_RD_REQ:  reg_rd_en = 1'b1;
            ST_WR_RESP: begin
                s.bvalid  = 1'b1;
                w_wr_done = s.bready;
            end
            ST_RD_RESP: begin
                s.rvalid  = 1'b1;
                w_rd_done = s.rready;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Response capture and arbitration
    // ------------------------------------------------------------------
    always_ff @(posedge axi4l_aclk) begin
        if (!axi4l_arstn) begin
            r_bresp   <= OKAY;
            r_rresp   <= OKAY;
            r_rdata   <= '0;
            r_prio_wr <= 1'b1;
        end else begin
            // Priority flips only when both sides competed, so uncontested
            // traffic does not disturb the alternation.
            if (r_state == ST_IDLE && w_wr_elig && w_rd_elig) begin
                r_prio_wr <= ~r_prio_wr;
            end
            if (r_state == ST_WR_REQ) begin
                if (reg_ack) begin
                    r_bresp <= reg_err ? SLVERR : OKAY;
                end else if (w_timeout) begin
                    r_bresp <= SLVERR;
                end
            end
            if (r_state == ST_RD_REQ) begin
                if (reg_ack) begin
                    r_rresp <= reg_err ? SLVERR : OKAY;
                    r_rdata <= reg_rdata;
                end else if (w_timeout) begin
                    r_rresp <= SLVERR;
                    r_rdata <= '0;
                end
            end
        end
    end

    assign s.bresp = r_bresp;
    assign s.rresp = r_rresp;
    assign s.rdata = r_rdata;

    // Register-bus address follows whichever side currently owns the bus.
    assign reg_addr  = (r_state == ST_RD_REQ) ? w_ar_addr : w_aw_addr;
    assign reg_wdata = w_w_beat[DATA_WIDTH+c_sw-1:c_sw];
    assign reg_wstrb = w_w_beat[c_sw-1:0];

endmodule
`default_nettype wire

// File: tb/tb_axi4l_reg_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_axi4l_reg_bridge
//  Purpose  : Directed self-checking bench for axi4l_reg_bridge with a
//             reactive register-bus model.
//  Config   : AXI4L_REG_TIMEOUT_EN enables the timeout scenario.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axi4l_reg_bridge;
    import axi4l_pkg::*;

    localparam int ADDR_WIDTH     = 32;
    localparam int DATA_WIDTH     = 32;
    localparam int TIMEOUT_CYCLES = 16;

    logic axi4l_aclk  = 1'b0;
    logic axi4l_arstn = 1'b0;
    always #5 axi4l_aclk = ~axi4l_aclk;

    axi4l_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

    logic [ADDR_WIDTH-3:0] reg_addr;
    logic                  reg_wr_en;
    logic                  reg_rd_en;
    logic [31:0]           reg_wdata;
    logic [3:0]            reg_wstrb;
    logic [31:0]           reg_rdata;
    logic                  reg_ack;
    logic                  reg_err;

    axi4l_reg_bridge #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .DATA_WIDTH     (DATA_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .axi4l_aclk  (axi4l_aclk),
        .axi4l_arstn (axi4l_arstn),
        .s           (bus),
        .reg_addr    (reg_addr),
        .reg_wr_en   (reg_wr_en),
        .reg_rd_en   (reg_rd_en),
        .reg_wdata   (reg_wdata),
        .reg_wstrb   (reg_wstrb),
        .reg_rdata   (reg_rdata),
        .reg_ack     (reg_ack),
        .reg_err     (reg_err)
    );

    // ---------------- reactive register model ----------------
    logic        m_ack_en    = 1'b1;
    logic        m_force_ack = 1'b0;
    int          m_delay     = 0;
    logic [31:0] m_rdata     = 32'h0;
    logic        m_err       = 1'b0;

    int          m_cnt        = 0;
    logic        m_prev_wr    = 1'b0;
    logic        m_prev_rd    = 1'b0;
    int          m_wr_pulses  = 0;
    int          m_rd_pulses  = 0;
    int          m_req_cycles = 0;
    int          cyc          = 0;
    logic [ADDR_WIDTH-3:0] m_last_addr  = '0;
    logic [31:0] m_last_wdata = 32'h0;
    logic [3:0]  m_last_wstrb = 4'h0;
    bit          m_log[$];

    assign reg_ack   = m_force_ack |
                       (m_ack_en & (reg_wr_en | reg_rd_en) & (m_cnt == m_delay));
    assign reg_rdata = m_rdata;
    assign reg_err   = m_err;

    always @(posedge axi4l_aclk) begin
        cyc       <= cyc + 1;
        m_cnt     <= (reg_wr_en | reg_rd_en) ? m_cnt + 1 : 0;
        m_prev_wr <= reg_wr_en;
        m_prev_rd <= reg_rd_en;
        if (reg_wr_en && !m_prev_wr) begin
            m_wr_pulses <= m_wr_pulses + 1;
            m_log.push_back(1'b1);
        end
        if (reg_rd_en && !m_prev_rd) begin
            m_rd_pulses <= m_rd_pulses + 1;
            m_log.push_back(1'b0);
        end
        if (reg_wr_en | reg_rd_en) m_req_cycles <= m_req_cycles + 1;
        if (reg_ack && (reg_wr_en | reg_rd_en)) begin
            m_last_addr  <= reg_addr;
            m_last_wdata <= reg_wdata;
            m_last_wstrb <= reg_wstrb;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge axi4l_aclk);
    endtask

    // ---------------- master BFM ----------------
    task automatic send_aw(input logic [31:0] addr, output int hs_cyc);
        hs_cyc = -1;
        bus.awaddr  = addr;
        bus.awvalid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if (bus.awready) begin
                tick();
                bus.awvalid = 1'b0;
                hs_cyc = cyc;
                return;
            end
            tick();
        end
        check("aw_handshake", bus.awready, 1);
        bus.awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb, output int waited);
        waited = -1;
        bus.wdata  = data;
        bus.wstrb  = strb;
        bus.wvalid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if (bus.wready) begin
                tick();
                bus.wvalid = 1'b0;
                waited = n;
                return;
            end
            tick();
        end
        check("w_handshake", bus.wready, 1);
        bus.wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] addr);
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if (bus.arready) begin
                tick();
                bus.arvalid = 1'b0;
                return;
            end
            tick();
        end
        check("ar_handshake", bus.arready, 1);
        bus.arvalid = 1'b0;
    endtask

    task automatic wait_b(input logic [1:0] exp_resp, input int hold, output int seen_cyc);
        seen_cyc = -1;
        for (int n = 0; n < 200 && !bus.bvalid; n++) tick();
        check("b_valid", bus.bvalid, 1);
        if (!bus.bvalid) return;
        seen_cyc = cyc;
        for (int k = 0; k < hold; k++) begin
            check("b_stable_valid", bus.bvalid, 1);
            check("b_stable_resp", bus.bresp, exp_resp);
            check("aw_blocked", bus.awready, 0);
            tick();
        end
        check("bresp", bus.bresp, exp_resp);
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
    endtask

    task automatic wait_r(input logic [1:0] exp_resp, input logic [31:0] exp_data, input int hold);
        for (int n = 0; n < 200 && !bus.rvalid; n++) tick();
        check("r_valid", bus.rvalid, 1);
        if (!bus.rvalid) return;
        for (int k = 0; k < hold; k++) begin
            check("r_stable_data", bus.rdata, exp_data);
            check("r_stable_resp", bus.rresp, exp_resp);
            tick();
        end
        check("rresp", bus.rresp, exp_resp);
        check("rdata", bus.rdata, exp_data);
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    int t_aw, t_w, t_b, t_dummy;
    int p0, r0, q0;

    initial begin
        bus.awaddr = '0; bus.awvalid = 1'b0;
        bus.wdata  = '0; bus.wstrb   = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        bus.araddr = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;

        // Reset values
        axi4l_arstn = 1'b0;
        repeat (3) tick();
        check("rst_awready", bus.awready, 0);
        check("rst_wready",  bus.wready,  0);
        check("rst_arready", bus.arready, 0);
        check("rst_bvalid",  bus.bvalid,  0);
        check("rst_rvalid",  bus.rvalid,  0);
        check("rst_bresp",   bus.bresp,   0);
        check("rst_rdata",   bus.rdata,   0);
        check("rst_wr_en",   reg_wr_en,   0);
        check("rst_rd_en",   reg_rd_en,   0);
        axi4l_arstn = 1'b1;
        tick();
        check("post_rst_awready", bus.awready, 1);

        // 1. Basic write, same-cycle ack
        m_delay = 0;
        p0 = m_wr_pulses; r0 = m_req_cycles;
        fork
            send_aw(32'h10, t_aw);
            send_w(32'hA5A5_5A5A, 4'hF, t_w);
        join
        wait_b(2'b00, 0, t_b);
        check("t1_addr",    m_last_addr, 30'h4);
        check("t1_wdata",   m_last_wdata, 32'hA5A5_5A5A);
        check("t1_wstrb",   m_last_wstrb, 4'hF);
        check("t1_pulses",  m_wr_pulses - p0, 1);
        check("t1_req_cyc", m_req_cycles - r0, 1);
        // AW accepted at edge e, bvalid visible after edge e+2
        check("t1_aw_to_b", t_b - t_aw, 2);

        // 2. W three cycles ahead of AW
        p0 = m_wr_pulses;
        send_w(32'h0BAD_F00D, 4'h3, t_w);
        check("t2_w_immediate", t_w, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_no_req", reg_wr_en, 0);
            check("t2_w_held", bus.wready, 0);
        end
        send_aw(32'h24, t_aw);
        wait_b(2'b00, 0, t_dummy);
        check("t2_pulses", m_wr_pulses - p0, 1);
        check("t2_addr",   m_last_addr, 30'h9);
        check("t2_wdata",  m_last_wdata, 32'h0BAD_F00D);
        check("t2_wstrb",  m_last_wstrb, 4'h3);

        // 3. Read with ack after 5 cycles
        m_delay = 5; m_rdata = 32'h1234_5678;
        p0 = m_rd_pulses; r0 = m_req_cycles;
        send_ar(32'h10);
        wait_r(2'b00, 32'h1234_5678, 0);
        check("t3_addr",    m_last_addr, 30'h4);
        check("t3_pulses",  m_rd_pulses - p0, 1);
        check("t3_req_cyc", m_req_cycles - r0, 6);

        // 4. Contested write/read, twice: write first, then read first
        m_delay = 0; m_rdata = 32'hCAFE_0001;
        q0 = m_log.size();
        fork
            send_aw(32'h30, t_aw);
            send_w(32'h1111_2222, 4'hF, t_w);
            send_ar(32'h40);
        join
        fork
            wait_b(2'b00, 0, t_dummy);
            wait_r(2'b00, 32'hCAFE_0001, 0);
        join
        fork
            send_aw(32'h50, t_aw);
            send_w(32'h3333_4444, 4'hF, t_w);
            send_ar(32'h60);
        join
        fork
            wait_b(2'b00, 0, t_dummy);
            wait_r(2'b00, 32'hCAFE_0001, 0);
        join
        check("t4_log_size", m_log.size() - q0, 4);
        check("t4_pair1_first_wr", m_log[q0],   1);
        check("t4_pair1_then_rd",  m_log[q0+1], 0);
        check("t4_pair2_first_rd", m_log[q0+2], 0);
        check("t4_pair2_then_wr",  m_log[q0+3], 1);

        // 5. Error write, BREADY held low for 10 cycles
        m_err = 1'b1;
        fork
            send_aw(32'h70, t_aw);
            send_w(32'h5555_AAAA, 4'hF, t_w);
        join
        wait_b(2'b10, 10, t_dummy);
        check("t5_awready_after_b", bus.awready, 1);
        m_err = 1'b0;

        // Reset asserted while a read request is pending
        m_ack_en = 1'b0;
        send_ar(32'h80);
        for (int n = 0; n < 50 && !reg_rd_en; n++) tick();
        check("rst_mid_rd_en_seen", reg_rd_en, 1);
        axi4l_arstn = 1'b0;
        tick();
        check("rst_mid_rd_en",   reg_rd_en,   0);
        check("rst_mid_rvalid",  bus.rvalid,  0);
        check("rst_mid_arready", bus.arready, 0);
        check("rst_mid_rdata",   bus.rdata,   0);
        check("rst_mid_rresp",   bus.rresp,   0);
        axi4l_arstn = 1'b1;
        tick();
        check("rst_mid_ar_empty", bus.arready, 1);

`ifdef AXI4L_REG_TIMEOUT_EN
        // 6. No ack: SLVERR after 16 request cycles; late ack ignored
        r0 = m_req_cycles;
        m_rdata = 32'hDEAD_BEEF;
        send_ar(32'h90);
        for (int n = 0; n < 100 && !bus.rvalid; n++) tick();
        check("t6_rvalid", bus.rvalid, 1);
        check("t6_req_cyc", m_req_cycles - r0, TIMEOUT_CYCLES);
        m_force_ack = 1'b1;
        wait_r(2'b10, 32'h0, 4);
        m_force_ack = 1'b0;
`endif
        m_ack_en = 1'b1;

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
